gpu_reg_file_2r1w: RTL and testbench

Parametrised register file for the GPU datapath with two independent registered read ports, one write port, write-first bypass, an optional hardwired zero register and a self-timed bulk-clear sequencer. It sits between the GPU instruction decoder (read addresses), the ALU (operands) and the writeback stage (write port). It extends the earlier single-read-port file with a second read port, a registered read path, reset, and a clear operation.

---
 rtl/gpu_reg_file_2r1w.sv | 141 ++++++++++++++
 tb/tb_gpu_reg_file_2r1w.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gpu_reg_file_2r1w.sv
// gpu_reg_file_2r1w: two registered read ports, one write port, write-first
// bypass, optional hardwired zero register and a self-timed bulk clear.
module gpu_reg_file_2r1w #(
  parameter int D_WIDTH  = 16,
  parameter int A_WIDTH  = 4,
  parameter int RF_DEPTH = 16,
  parameter int ZERO_REG = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] read_addr_a,
  input  logic [A_WIDTH-1:0] read_addr_b,
  output logic [D_WIDTH-1:0] read_data_a,
  output logic [D_WIDTH-1:0] read_data_b,
  input  logic [A_WIDTH-1:0] write_addr,
  input  logic [D_WIDTH-1:0] write_data,
  input  logic               write_enable,
  output logic               write_ready,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic               clear_done
);
  // One extra counter bit so a full 2^A_WIDTH sweep can still hit its last index.
  localparam int CW = A_WIDTH + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                           state_q;
  logic                             clear_busy_q, clear_done_q;
  logic [A_WIDTH:0]                 cnt_q;
  logic [RF_DEPTH-1:0][D_WIDTH-1:0] mem;
  logic [D_WIDTH-1:0]               rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic                             wr_acc;

  // Address maps to a real, writable/readable register (not out of range,
  // not the hardwired zero register).
  function automatic logic addr_ok(input logic [A_WIDTH-1:0] a);
    return ({1'b0, a} < CW'(RF_DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Write-first read value: accepted write bypasses, the sweep counts as a
  // write of zero, otherwise the stored register.
  function automatic logic [D_WIDTH-1:0] rd_next(
    input logic [A_WIDTH-1:0]                 a,
    input logic [RF_DEPTH-1:0][D_WIDTH-1:0]   m,
    input logic                               wacc,
    input logic [A_WIDTH-1:0]                 wa,
    input logic [D_WIDTH-1:0]                 wd,
    input logic                               sweep,
    input logic [A_WIDTH:0]                   cnt
  );
    logic [D_WIDTH-1:0] v;
    v = '0;
    if (!addr_ok(a))                    v = '0;
    else if (wacc && (a == wa))         v = wd;
    else if (sweep && ({1'b0, a} == cnt)) v = '0;
    else
      for (int i = 0; i < RF_DEPTH; i++)
        if ({1'b0, a} == CW'(i)) v = m[i];
    return v;
  endfunction

  assign write_ready = !clear_busy_q;
  assign wr_acc      = write_enable && write_ready && addr_ok(write_addr);
  assign clear_busy  = clear_busy_q;
  assign clear_done  = clear_done_q;
  assign read_data_a = rd_a_q;
  assign read_data_b = rd_b_q;

  // Storage: one register per entry; sweep and write never coincide because
  // write_ready is low for the whole sweep.
  for (genvar i = 0; i < RF_DEPTH; i++) begin : g_reg
    logic [D_WIDTH-1:0] reg_q, reg_d;
    logic               sweep_hit, wr_hit;

    assign sweep_hit = clear_busy_q && (cnt_q == CW'(i));
    assign wr_hit    = wr_acc && ({1'b0, write_addr} == CW'(i));
    assign mem[i]    = reg_q;

    // Next-state for this entry: sweep zero, else accepted write, else hold.
    always_comb begin
      reg_d = reg_q;
      if (sweep_hit)   reg_d = '0;
      else if (wr_hit) reg_d = write_data;
    end

    // Entry register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) reg_q <= '0;
      else     reg_q <= reg_d;
    end
  end

  // Read-port next values.
  always_comb begin
    rd_a_d = rd_next(read_addr_a, mem, wr_acc, write_addr, write_data, clear_busy_q, cnt_q);
    rd_b_d = rd_next(read_addr_b, mem, wr_acc, write_addr, write_data, clear_busy_q, cnt_q);
  end

  // Registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  // Clear sequencer: one entry per cycle, done pulse after the last one.
  // A clear_req arriving mid-sweep is dropped, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      clear_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q      <= CLEAR;
            clear_busy_q <= 1'b1;
            cnt_q        <= '0;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(RF_DEPTH - 1)) begin
            state_q      <= IDLE;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_reg_file_2r1w.sv
// Directed bench for gpu_reg_file_2r1w: a default 16-deep file plus a
// 12-deep file with the zero register enabled, sharing all inputs.
module tb_gpu_reg_file_2r1w;
  logic        clk, rst;
  logic [3:0]  ra, rb, wa;
  logic [15:0] wd;
  logic        we, creq;
  logic [15:0] rda, rdb, zrda, zrdb;
  logic        wrdy, busy, done, zwrdy, zbusy, zdone;

  int checks = 0;
  int errors = 0;

  gpu_reg_file_2r1w #(.D_WIDTH(16), .A_WIDTH(4), .RF_DEPTH(16), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst),
    .read_addr_a(ra), .read_addr_b(rb), .read_data_a(rda), .read_data_b(rdb),
    .write_addr(wa), .write_data(wd), .write_enable(we), .write_ready(wrdy),
    .clear_req(creq), .clear_busy(busy), .clear_done(done));

  gpu_reg_file_2r1w #(.D_WIDTH(16), .A_WIDTH(4), .RF_DEPTH(12), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst),
    .read_addr_a(ra), .read_addr_b(rb), .read_data_a(zrda), .read_data_b(zrdb),
    .write_addr(wa), .write_data(wd), .write_enable(we), .write_ready(zwrdy),
    .clear_req(creq), .clear_busy(zbusy), .clear_done(zdone));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra, rb;
    logic [15:0] ea, eb;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [3:0] a, input logic [15:0] d,
                       input logic [3:0] pa, input logic [3:0] pb, input logic c);
    we = w; wa = a; wd = d; ra = pa; rb = pb; creq = c;
  endtask

  initial begin
    int n;
    logic seen;
    tbl[0] = '{1'b1, 4'd3,  16'h1234, 4'd0,  4'd1,  16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd3,  16'h1234, 16'h1234};
    tbl[2] = '{1'b1, 4'd5,  16'hBEEF, 4'd5,  4'd3,  16'hBEEF, 16'h1234};
    tbl[3] = '{1'b1, 4'd6,  16'h0606, 4'd6,  4'd6,  16'h0606, 16'h0606};
    tbl[4] = '{1'b0, 4'd6,  16'hDEAD, 4'd5,  4'd6,  16'hBEEF, 16'h0606};
    tbl[5] = '{1'b1, 4'd15, 16'hF00F, 4'd15, 4'd0,  16'hF00F, 16'h0000};
    tbl[6] = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd5,  16'hF00F, 16'hBEEF};
    tbl[7] = '{1'b1, 4'd3,  16'h3333, 4'd5,  4'd3,  16'hBEEF, 16'h3333};
    tbl[8] = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd15, 16'h3333, 16'hF00F};

    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);
    #12 rst = 1'b0;

    // Reset state on every address of both ports.
    chk("rst_busy", {15'b0, busy}, 16'h0);
    chk("rst_done", {15'b0, done}, 16'h0);
    chk("rst_ready", {15'b0, wrdy}, 16'h1);
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 4'd0, 16'h0, 4'(a), 4'(15 - a), 1'b0);
      tick();
      chk("rst_rd_a", rda, 16'h0);
      chk("rst_rd_b", rdb, 16'h0);
    end

    // Table vectors: write, read-back, bypass on one and both ports.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, 1'b0);
      tick();
      chk($sformatf("vec%0d_a", i), rda, tbl[i].ea);
      chk($sformatf("vec%0d_b", i), rdb, tbl[i].eb);
    end

    // Zero register and out-of-range address on the 12-deep instance.
    drive(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b0);
    tick();
    chk("z_r0_bypass", zrda, 16'h0);
    chk("def_r0_bypass", rda, 16'hFFFF);
    drive(1'b1, 4'd13, 16'hABCD, 4'd13, 4'd0, 1'b0);
    tick();
    chk("z_oob_bypass", zrda, 16'h0);
    chk("z_r0_after", zrdb, 16'h0);
    chk("def_13_bypass", rda, 16'hABCD);
    chk("def_r0_stored", rdb, 16'hFFFF);
    drive(1'b1, 4'd11, 16'h1111, 4'd11, 4'd13, 1'b0);
    tick();
    chk("z_last_bypass", zrda, 16'h1111);
    chk("z_oob_read", zrdb, 16'h0);
    drive(1'b0, 4'd0, 16'h0, 4'd11, 4'd0, 1'b0);
    tick();
    chk("z_last_stored", zrda, 16'h1111);
    chk("z_r0_read", zrdb, 16'h0);

    // Fill, then sweep with in-flight reads, a dropped write and a re-request.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 16'hA5A0 + 16'(i), 4'd0, 4'd0, 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1);
    tick();                                    // edge E
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("sw%0d_busy", k), {15'b0, busy}, 16'h1);
      chk($sformatf("sw%0d_ready", k), {15'b0, wrdy}, 16'h0);
      chk($sformatf("sw%0d_done", k), {15'b0, done}, 16'h0);
      drive(k == 8, 4'd1, 16'h7777, 4'(k), (k + 2 < 16) ? 4'(k + 2) : 4'(k), k == 5);
      tick();
      chk($sformatf("sw%0d_rd_k", k), rda, 16'h0);
      chk($sformatf("sw%0d_rd_k2", k), rdb, (k + 2 < 16) ? 16'hA5A0 + 16'(k + 2) : 16'h0);
    end
    chk("sw_end_busy", {15'b0, busy}, 16'h0);
    chk("sw_end_done", {15'b0, done}, 16'h1);
    chk("sw_end_ready", {15'b0, wrdy}, 16'h1);
    drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);
    tick();
    chk("sw_done_once", {15'b0, done}, 16'h0);
    chk("sw_no_requeue", {15'b0, busy}, 16'h0);
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 4'd0, 16'h0, 4'(a), 4'(15 - a), 1'b0);
      tick();
      chk($sformatf("clr_rd_a%0d", a), rda, 16'h0);
      chk($sformatf("clr_rd_b%0d", 15 - a), rdb, 16'h0);
    end

    // clear_req with a same-cycle write: write commits, sweep then zeroes it.
    drive(1'b1, 4'd7, 16'h4444, 4'd7, 4'd7, 1'b1);
    tick();
    chk("cw_bypass", rda, 16'h4444);
    drive(1'b0, 4'd0, 16'h0, 4'd7, 4'd7, 1'b0);
    tick();
    chk("cw_commit", rdb, 16'h4444);
    n = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (done) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    chk("cw_done_seen", {15'b0, seen}, 16'h1);
    chk("cw_done_cycle", 16'(n), 16'd16);
    chk("cw_r7_zero", rda, 16'h0);

    // Asynchronous reset mid-sweep.
    drive(1'b1, 4'd2, 16'h2222, 4'd2, 4'd2, 1'b1);
    tick();
    chk("mr_bypass", rda, 16'h2222);
    drive(1'b0, 4'd0, 16'h0, 4'd2, 4'd2, 1'b0);
    tick();
    tick();
    chk("mr_busy_pre", {15'b0, busy}, 16'h1);
    rst = 1'b1;
    #1;
    chk("mr_rd_a", rda, 16'h0);
    chk("mr_rd_b", rdb, 16'h0);
    chk("mr_busy", {15'b0, busy}, 16'h0);
    chk("mr_ready", {15'b0, wrdy}, 16'h1);
    #1 rst = 1'b0;
    tick();
    chk("mr_r2_cleared", rda, 16'h0);
    chk("mr_busy_post", {15'b0, busy}, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
